// File: rtl/ex_mem_stage_if.sv
// EX->MEM stage bundle: EX-side inputs, MEM-side outputs, flush and fetch redirect.
// Forwarding signals exist only when EXMEM_FWD_EN is defined.
interface ex_mem_stage_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR_W    = 5
);
  logic                     ex_valid;
  logic                     ex_ready;
  logic [DATA_WIDTH-1:0]    ex_alu_result;
  logic [OPCODE_LENGTH-1:0] ex_operation;
  logic                     ex_is_branch;
  logic [DATA_WIDTH-1:0]    ex_branch_target;
  logic [DATA_WIDTH-1:0]    ex_store_data;
  logic [REG_ADDR_W-1:0]    ex_rd;
  logic                     ex_reg_write;
  logic                     ex_mem_read;
  logic                     ex_mem_write;
  logic                     flush;
  logic                     mem_valid;
  logic                     mem_ready;
  logic [DATA_WIDTH-1:0]    mem_alu_result;
  logic [DATA_WIDTH-1:0]    mem_store_data;
  logic [REG_ADDR_W-1:0]    mem_rd;
  logic                     mem_reg_write;
  logic                     mem_mem_read;
  logic                     mem_mem_write;
  logic                     pc_redirect;
  logic [DATA_WIDTH-1:0]    pc_target;
`ifdef EXMEM_FWD_EN
  logic                     fwd_valid;
  logic [REG_ADDR_W-1:0]    fwd_rd;
  logic [DATA_WIDTH-1:0]    fwd_data;
`endif

  modport slave (
    input  ex_valid, ex_alu_result, ex_operation, ex_is_branch, ex_branch_target,
           ex_store_data, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, flush, mem_ready,
    output ex_ready, mem_valid, mem_alu_result, mem_store_data, mem_rd, mem_reg_write,
           mem_mem_read, mem_mem_write, pc_redirect, pc_target
`ifdef EXMEM_FWD_EN
    , output fwd_valid, fwd_rd, fwd_data
`endif
  );

  modport master (
    output ex_valid, ex_alu_result, ex_operation, ex_is_branch, ex_branch_target,
           ex_store_data, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, flush, mem_ready,
    input  ex_ready, mem_valid, mem_alu_result, mem_store_data, mem_rd, mem_reg_write,
           mem_mem_read, mem_mem_write, pc_redirect, pc_target
`ifdef EXMEM_FWD_EN
    , input fwd_valid, fwd_rd, fwd_data
`endif
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline stage: output register plus one skid entry, branch/jump redirect.
// Define EXMEM_FWD_EN to add combinational forwarding outputs from the output register.
module ex_mem_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR_W    = 5
) (
  input logic           clk,
  input logic           reset,
  ex_mem_stage_if.slave bus
);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] aluResult;
    logic [DATA_WIDTH-1:0] storeData;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regWrite;
    logic                  memRead;
    logic                  memWrite;
  } entry_t;

  entry_t                out_q, out_d, skid_q, skid_d, inEntry;
  logic                  outValid_q, outValid_d;
  logic                  skidValid_q, skidValid_d;
  logic                  redirect_q, redirect_d;
  logic [DATA_WIDTH-1:0] target_q, target_d;
  logic                  accept, taken;
  logic [DATA_WIDTH-1:0] branchTarget;

  assign accept  = bus.ex_valid && !skidValid_q;
  assign inEntry = '{aluResult: bus.ex_alu_result, storeData: bus.ex_store_data,
                     rd: bus.ex_rd, regWrite: bus.ex_reg_write,
                     memRead: bus.ex_mem_read, memWrite: bus.ex_mem_write};

  always_comb begin
    taken        = 1'b0;
    branchTarget = bus.ex_branch_target;
    if (bus.ex_is_branch) begin
      case (bus.ex_operation)
        4'b1000, 4'b1010, 4'b1011, 4'b1101: taken = bus.ex_alu_result[0];
        4'b1110: taken = 1'b1;
        4'b1111: begin
          taken        = 1'b1;
          branchTarget = {bus.ex_alu_result[DATA_WIDTH-1:1], 1'b0};
        end
        default: taken = 1'b0;
      endcase
    end
  end

  // The skid only ever fills while the output is held, and ex_ready is low while it is full,
  // so an accept never coincides with a valid skid entry.
  always_comb begin
    out_d       = out_q;
    skid_d      = skid_q;
    outValid_d  = outValid_q;
    skidValid_d = skidValid_q;
    redirect_d  = accept && taken;
    target_d    = (accept && taken) ? branchTarget : target_q;
    if (!outValid_q || bus.mem_ready) begin
      if (skidValid_q) begin
        out_d       = skid_q;
        outValid_d  = 1'b1;
        skidValid_d = 1'b0;
      end else if (accept) begin
        out_d      = inEntry;
        outValid_d = 1'b1;
      end else begin
        outValid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d      = inEntry;
      skidValid_d = 1'b1;
    end
    if (bus.flush) begin
      outValid_d  = 1'b0;
      skidValid_d = 1'b0;
      redirect_d  = 1'b0;
      target_d    = target_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_q       <= '0;
      skid_q      <= '0;
      outValid_q  <= 1'b0;
      skidValid_q <= 1'b0;
      redirect_q  <= 1'b0;
      target_q    <= '0;
    end else begin
      out_q       <= out_d;
      skid_q      <= skid_d;
      outValid_q  <= outValid_d;
      skidValid_q <= skidValid_d;
      redirect_q  <= redirect_d;
      target_q    <= target_d;
    end
  end

  assign bus.ex_ready       = !skidValid_q;
  assign bus.mem_valid      = outValid_q;
  assign bus.mem_alu_result = out_q.aluResult;
  assign bus.mem_store_data = out_q.storeData;
  assign bus.mem_rd         = out_q.rd;
  assign bus.mem_reg_write  = outValid_q && out_q.regWrite;
  assign bus.mem_mem_read   = outValid_q && out_q.memRead;
  assign bus.mem_mem_write  = outValid_q && out_q.memWrite;
  assign bus.pc_redirect    = redirect_q;
  assign bus.pc_target      = target_q;

`ifdef EXMEM_FWD_EN
  // Loads are excluded: their data is not known until the memory stage returns it.
  assign bus.fwd_valid = outValid_q && out_q.regWrite && !out_q.memRead && (out_q.rd != '0);
  assign bus.fwd_rd    = out_q.rd;
  assign bus.fwd_data  = out_q.aluResult;
`endif
endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed testbench for ex_mem_stage: streaming, skid backpressure, redirect decode, flush, reset.
module tb_ex_mem_stage;
  logic clk = 1'b0;
  logic reset;
  int   testsRun = 0;
  int   failCount = 0;

  always #5 clk = ~clk;

  ex_mem_stage_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .REG_ADDR_W(5)) bus ();

  ex_mem_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .REG_ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one EX bundle; valid=0 leaves an idle input.
  task automatic applyStimulus(input logic valid, input logic [31:0] result, input logic [3:0] op,
                               input logic isBranch, input logic [31:0] target,
                               input logic [31:0] storeData, input logic [4:0] rd,
                               input logic regWrite, input logic memRead, input logic memWrite);
    bus.ex_valid         = valid;
    bus.ex_alu_result    = result;
    bus.ex_operation     = op;
    bus.ex_is_branch     = isBranch;
    bus.ex_branch_target = target;
    bus.ex_store_data    = storeData;
    bus.ex_rd            = rd;
    bus.ex_reg_write     = regWrite;
    bus.ex_mem_read      = memRead;
    bus.ex_mem_write     = memWrite;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b0;
    bus.flush     = 1'b0;
    bus.mem_ready = 1'b1;
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset_mem_valid", 32'(bus.mem_valid), 32'h0);
    checkOutput("reset_pc_redirect", 32'(bus.pc_redirect), 32'h0);
    checkOutput("reset_alu_result", bus.mem_alu_result, 32'h0);
    checkOutput("reset_pc_target", bus.pc_target, 32'h0);
    reset = 1'b1;
    tick();
    checkOutput("reset_ex_ready", 32'(bus.ex_ready), 32'h1);

    // Four back-to-back ADD results with MEM always ready
    applyStimulus(1'b1, 32'h10, 4'h0, 1'b0, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("stream0_valid", 32'(bus.mem_valid), 32'h1);
    checkOutput("stream0_result", bus.mem_alu_result, 32'h10);
    checkOutput("stream0_rd", 32'(bus.mem_rd), 32'd3);
    checkOutput("stream0_regwrite", 32'(bus.mem_reg_write), 32'h1);
`ifdef EXMEM_FWD_EN
    checkOutput("fwd_valid_alu", 32'(bus.fwd_valid), 32'h1);
    checkOutput("fwd_data_alu", bus.fwd_data, 32'h10);
`endif
    applyStimulus(1'b1, 32'h20, 4'h0, 1'b0, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("stream1_result", bus.mem_alu_result, 32'h20);
    checkOutput("stream1_valid", 32'(bus.mem_valid), 32'h1);
    applyStimulus(1'b1, 32'h30, 4'h0, 1'b0, 32'h0, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("stream2_result", bus.mem_alu_result, 32'h30);
    applyStimulus(1'b1, 32'h40, 4'h0, 1'b0, 32'h0, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("stream3_result", bus.mem_alu_result, 32'h40);
    checkOutput("stream3_ex_ready", 32'(bus.ex_ready), 32'h1);
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("drain_valid", 32'(bus.mem_valid), 32'h0);
    checkOutput("drain_regwrite_gated", 32'(bus.mem_reg_write), 32'h0);

    // Backpressure: 0xA held in the output register, 0xB lands in the skid
    bus.mem_ready = 1'b0;
    applyStimulus(1'b1, 32'hA, 4'h0, 1'b0, 32'h0, 32'hDEAD, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("bp_a_valid", 32'(bus.mem_valid), 32'h1);
    checkOutput("bp_a_ready", 32'(bus.ex_ready), 32'h1);
    checkOutput("bp_a_store_data", bus.mem_store_data, 32'hDEAD);
    checkOutput("bp_a_mem_write", 32'(bus.mem_mem_write), 32'h1);
    applyStimulus(1'b1, 32'hB, 4'h0, 1'b0, 32'h0, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("bp_held_result", bus.mem_alu_result, 32'hA);
    checkOutput("bp_skid_ex_ready", 32'(bus.ex_ready), 32'h0);
    applyStimulus(1'b1, 32'hC, 4'h0, 1'b0, 32'h0, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("bp_stall_held", bus.mem_alu_result, 32'hA);
    checkOutput("bp_stall_ex_ready", 32'(bus.ex_ready), 32'h0);
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    bus.mem_ready = 1'b1;
    tick();
    checkOutput("bp_b_result", bus.mem_alu_result, 32'hB);
    checkOutput("bp_b_valid", 32'(bus.mem_valid), 32'h1);
    checkOutput("bp_b_mem_read", 32'(bus.mem_mem_read), 32'h1);
    checkOutput("bp_after_drain_ready", 32'(bus.ex_ready), 32'h1);
`ifdef EXMEM_FWD_EN
    checkOutput("fwd_valid_load", 32'(bus.fwd_valid), 32'h0);
`endif
    tick();
    checkOutput("bp_empty_valid", 32'(bus.mem_valid), 32'h0);

    // Branch / jump redirect decode
    applyStimulus(1'b1, 32'h1, 4'b1000, 1'b1, 32'h100, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("beq_taken_redirect", 32'(bus.pc_redirect), 32'h1);
    checkOutput("beq_taken_target", bus.pc_target, 32'h100);
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("redirect_one_cycle", 32'(bus.pc_redirect), 32'h0);
    checkOutput("target_holds", bus.pc_target, 32'h100);
    applyStimulus(1'b1, 32'h0, 4'b1000, 1'b1, 32'h200, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("beq_not_taken", 32'(bus.pc_redirect), 32'h0);
    checkOutput("beq_not_taken_target", bus.pc_target, 32'h100);
    applyStimulus(1'b1, 32'h1, 4'b1101, 1'b1, 32'h280, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("op1101_taken", 32'(bus.pc_redirect), 32'h1);
    checkOutput("op1101_target", bus.pc_target, 32'h280);
    applyStimulus(1'b1, 32'h1, 4'b1110, 1'b0, 32'h300, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("jal_unqualified", 32'(bus.pc_redirect), 32'h0);
    applyStimulus(1'b1, 32'h1, 4'b1001, 1'b1, 32'h380, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("other_op_not_taken", 32'(bus.pc_redirect), 32'h0);
    applyStimulus(1'b1, 32'h0, 4'b1110, 1'b1, 32'h300, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("jal_redirect", 32'(bus.pc_redirect), 32'h1);
    checkOutput("jal_target", bus.pc_target, 32'h300);
    applyStimulus(1'b1, 32'h2003, 4'b1111, 1'b1, 32'h999, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("jalr_redirect", 32'(bus.pc_redirect), 32'h1);
    checkOutput("jalr_target", bus.pc_target, 32'h2002);
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();

    // Flush with the skid full, then flush alongside an accepted jump
    bus.mem_ready = 1'b0;
    applyStimulus(1'b1, 32'hC0, 4'h0, 1'b0, 32'h0, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'hD0, 4'h0, 1'b0, 32'h0, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("pre_flush_ex_ready", 32'(bus.ex_ready), 32'h0);
    applyStimulus(1'b1, 32'hE0, 4'b1110, 1'b1, 32'h400, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0);
    bus.flush = 1'b1;
    tick();
    checkOutput("flush_mem_valid", 32'(bus.mem_valid), 32'h0);
    checkOutput("flush_ex_ready", 32'(bus.ex_ready), 32'h1);
    checkOutput("flush_redirect", 32'(bus.pc_redirect), 32'h0);
    tick();
    checkOutput("flush_accept_dropped", 32'(bus.mem_valid), 32'h0);
    checkOutput("flush_accept_no_redirect", 32'(bus.pc_redirect), 32'h0);
    checkOutput("flush_accept_target_kept", bus.pc_target, 32'h2002);
    checkOutput("flush_accept_ex_ready", 32'(bus.ex_ready), 32'h1);
    bus.flush     = 1'b0;
    bus.mem_ready = 1'b1;
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("post_flush_empty", 32'(bus.mem_valid), 32'h0);

    // Reset in the middle of a stall, right as a jump is accepted
    bus.mem_ready = 1'b0;
    applyStimulus(1'b1, 32'hF0, 4'h0, 1'b0, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'hF4, 4'b1110, 1'b1, 32'h500, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("stall_jump_redirect", 32'(bus.pc_redirect), 32'h1);
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    checkOutput("midreset_mem_valid", 32'(bus.mem_valid), 32'h0);
    checkOutput("midreset_redirect", 32'(bus.pc_redirect), 32'h0);
    checkOutput("midreset_ex_ready", 32'(bus.ex_ready), 32'h1);
    checkOutput("midreset_result", bus.mem_alu_result, 32'h0);
    checkOutput("midreset_target", bus.pc_target, 32'h0);
    reset         = 1'b1;
    bus.mem_ready = 1'b1;
    tick();
    checkOutput("after_reset_empty", 32'(bus.mem_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end
endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX→MEM pipeline stage directly downstream of the ALU.
- Captures ALUResult plus control and store data into a 2-entry skid buffer with valid/ready handshakes on both sides.
- Resolves branches and jumps from the ALU operation code and result, and issues a one-cycle PC redirect to fetch.
- Decouples ALU timing from memory-stage backpressure; ex_ready is a registered signal.

Parameters:
DATA_WIDTH, 32, width of ALU result, store data, PC and target
OPCODE_LENGTH, 4, width of ALU operation code
REG_ADDR_W, 5, destination register index width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset; sampled on rising clk
ex_valid  in  1  EX bundle valid
ex_ready  out  1  stage can accept (registered, equals !skid_valid)
ex_alu_result  in  DATA_WIDTH  ALUResult from ALU
ex_operation  in  OPCODE_LENGTH  ALU Operation code for this instruction
ex_is_branch  in  1  instruction is conditional branch/jump (qualifies opcode decode)
ex_branch_target  in  DATA_WIDTH  PC+imm from EX
ex_store_data  in  DATA_WIDTH  rs2 value for stores
ex_rd  in  REG_ADDR_W  destination register
ex_reg_write  in  1  writeback enable
ex_mem_read  in  1  load
ex_mem_write  in  1  store
flush  in  1  kill all held entries
mem_valid  out  1  MEM bundle valid
mem_ready  in  1  MEM accepts
mem_alu_result  out  DATA_WIDTH  held result/address
mem_store_data  out  DATA_WIDTH  held store data
mem_rd  out  REG_ADDR_W  held rd
mem_reg_write  out  1  held, gated by mem_valid
mem_mem_read  out  1  held, gated by mem_valid
mem_mem_write  out  1  held, gated by mem_valid
pc_redirect  out  1  one-cycle redirect pulse
pc_target  out  DATA_WIDTH  redirect target

Behaviour:
- Reset (reset==0 at clk edge): out_valid, skid_valid, pc_redirect = 0; all data outputs = 0; ex_ready = 1 in the following cycle.
- Accept = ex_valid && ex_ready. Handoff = mem_valid && mem_ready.
- Output register update when (!out_valid || mem_ready):
  - skid_valid → out ← skid, skid_valid ← 0.
  - else accept → out ← input.
  - else out_valid ← 0.
- When out is held (out_valid && !mem_ready) and accept → skid ← input, skid_valid ← 1.
- Latency 1 cycle input→mem_valid when not stalled. Full throughput with mem_ready held high. No entry is dropped or duplicated.
- ex_ready deasserts the cycle after the skid fills and reasserts the cycle after the skid drains.
- mem_reg_write/mem_mem_read/mem_mem_write are 0 whenever mem_valid = 0.
- Redirect decode, evaluated on accept only, when ex_is_branch = 1:
  - ops 1000, 1010, 1011, 1101: taken = ex_alu_result[0]; target = ex_branch_target.
  - op 1110: taken = 1; target = ex_branch_target.
  - op 1111: taken = 1; target = ex_alu_result with bit0 cleared.
  - any other opcode: not taken.
- pc_redirect is registered: high exactly one cycle after the accept edge, low otherwise. pc_target holds its last value.
- flush = 1 at clock edge: out_valid, skid_valid, pc_redirect ← 0. An accept in the same cycle is discarded, and ex_ready stays 1.
- flush has priority over mem_ready/accept. reset has priority over flush.
- Reset mid-stall discards all entries with no redirect.

Optional Feature:
- Macro: EXMEM_FWD_EN.
- Defined: adds outputs fwd_valid (1), fwd_rd (REG_ADDR_W), fwd_data (DATA_WIDTH), driven combinationally from the output register.
  - fwd_valid = mem_valid && mem_reg_write && !mem_mem_read && mem_rd != 0.
  - Used for EX operand forwarding.
- Undefined: ports absent; no extra logic.

Test Plan:
- Reset with reset=0 for 2 cycles → mem_valid=0, pc_redirect=0, ex_ready=1 one cycle after release.
- Stream of 4 ADD results 0x10,0x20,0x30,0x40, mem_ready=1 → mem_alu_result matches 1 cycle later each, no bubbles.
- mem_ready=0 while sending 0xA, 0xB → 0xA held, 0xB in skid, ex_ready=0. Then mem_ready=1 → 0xA then 0xB in order, ex_ready=1 after drain.
- BEQ (op 1000, result 1, target 0x100) → pc_redirect=1 one cycle, pc_target=0x100. Same with result 0 → no redirect.
- JALR (op 1111, result 0x2003) → pc_target=0x2002.
- flush asserted while skid full plus new accept → next cycle mem_valid=0, ex_ready=1, pc_redirect=0.
